stream_fork_buffered: RTL and testbench

STREAM_FORK_BUFFERED -- requirements
Module: stream_fork_buffered

---
 rtl/stream_fork_buffered.sv | 128 ++++++++++++
 tb/tb_stream_fork_buffered.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_fork_buffered.sv
// Broadcast fork: each upstream word is copied into two independent FIFOs, one per output.
// Optional STREAM_FORK_CNT_EN adds 16-bit per-output handshake counters (cnt_a, cnt_b).

module stream_fork_buffered_fifo #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [D_WIDTH-1:0] push_data,
  input  logic               pop,
  output logic [D_WIDTH-1:0] head,
  output logic               not_empty,
  output logic               full
);
  localparam int DEPTH = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0]   CNT_FULL = (A_WIDTH + 1)'(DEPTH);
  localparam logic [A_WIDTH:0]   CNT_ONE  = 1;
  localparam logic [A_WIDTH-1:0] PTR_ONE  = 1;

  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH:0]   count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage is cleared on reset so the head reads zero until the first write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head      = mem[rd_ptr];
  assign not_empty = (count != '0);
  assign full      = (count == CNT_FULL);
endmodule

module stream_fork_buffered #(
  parameter int D_WIDTH = 6,
  parameter int A_WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
`ifdef STREAM_FORK_CNT_EN
  output logic [15:0]        cnt_a,
  output logic [15:0]        cnt_b,
`endif
  input  logic [D_WIDTH-1:0] up_data,
  input  logic               up_valid,
  output logic               up_ready,
  output logic [D_WIDTH-1:0] down_data_a,
  output logic               down_valid_a,
  input  logic               down_ready_a,
  output logic [D_WIDTH-1:0] down_data_b,
  output logic               down_valid_b,
  input  logic               down_ready_b
);
  logic ready_en;
  logic full_a;
  logic full_b;
  logic push;
  logic pop_a;
  logic pop_b;

  // Holds up_ready low during reset; rises on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ready_en <= 1'b0;
    else      ready_en <= 1'b1;
  end

  assign up_ready = ready_en & ~full_a & ~full_b;
  assign push     = up_valid & up_ready;
  assign pop_a    = down_valid_a & down_ready_a;
  assign pop_b    = down_valid_b & down_ready_b;

  stream_fork_buffered_fifo #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_fifo_a (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (up_data),
    .pop       (pop_a),
    .head      (down_data_a),
    .not_empty (down_valid_a),
    .full      (full_a)
  );

  stream_fork_buffered_fifo #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_fifo_b (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (up_data),
    .pop       (pop_b),
    .head      (down_data_b),
    .not_empty (down_valid_b),
    .full      (full_b)
  );

`ifdef STREAM_FORK_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (pop_a) cnt_a <= cnt_a + 16'd1;
      if (pop_b) cnt_b <= cnt_b + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stream_fork_buffered.sv
// Bench for stream_fork_buffered: scoreboard queues per output fed on upstream accept.
module tb_stream_fork_buffered;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] up_data;
  logic       up_valid;
  logic       up_ready;
  logic [5:0] down_data_a;
  logic       down_valid_a;
  logic       down_ready_a;
  logic [5:0] down_data_b;
  logic       down_valid_b;
  logic       down_ready_b;
`ifdef STREAM_FORK_CNT_EN
  logic [15:0] cnt_a;
  logic [15:0] cnt_b;
`endif

  int checks = 0;
  int errors = 0;
  int pop_a_n = 0;
  int pop_b_n = 0;
  int push_n = 0;
  logic [5:0] exp_a[$];
  logic [5:0] exp_b[$];

  stream_fork_buffered dut (
    .clk          (clk),
    .rst          (rst),
`ifdef STREAM_FORK_CNT_EN
    .cnt_a        (cnt_a),
    .cnt_b        (cnt_b),
`endif
    .up_data      (up_data),
    .up_valid     (up_valid),
    .up_ready     (up_ready),
    .down_data_a  (down_data_a),
    .down_valid_a (down_valid_a),
    .down_ready_a (down_ready_a),
    .down_data_b  (down_data_b),
    .down_valid_b (down_valid_b),
    .down_ready_b (down_ready_b)
  );

  always #5 clk = ~clk;

  // Scoreboard: sample handshakes half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (down_valid_a && down_ready_a) begin
        checks++;
        pop_a_n++;
        if (exp_a.size() == 0) begin
          errors++;
          $display("FAIL out_a_unexpected got %h required none", down_data_a);
        end else begin
          logic [5:0] e;
          e = exp_a.pop_front();
          if (down_data_a !== e) begin
            errors++;
            $display("FAIL out_a_order got %h required %h", down_data_a, e);
          end
        end
      end
      if (down_valid_b && down_ready_b) begin
        checks++;
        pop_b_n++;
        if (exp_b.size() == 0) begin
          errors++;
          $display("FAIL out_b_unexpected got %h required none", down_data_b);
        end else begin
          logic [5:0] e;
          e = exp_b.pop_front();
          if (down_data_b !== e) begin
            errors++;
            $display("FAIL out_b_order got %h required %h", down_data_b, e);
          end
        end
      end
      if (up_valid && up_ready) begin
        push_n++;
        exp_a.push_back(up_data);
        exp_b.push_back(up_data);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [5:0] d, input int max_wait, output bit ok, output int waits);
    up_data  = d;
    up_valid = 1'b1;
    ok       = 1'b0;
    waits    = 0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      @(negedge clk);
      if (up_ready) ok = 1'b1;
      else waits++;
      @(posedge clk);
      #1;
    end
    up_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    exp_a.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    up_valid = 1'b0;
    up_data = '0;
    down_ready_a = 1'b0;
    down_ready_b = 1'b0;
    #3;
    checks++; if (down_valid_a !== 1'b0) begin errors++; $display("FAIL rst_valid_a got %b required 0", down_valid_a); end
    checks++; if (down_valid_b !== 1'b0) begin errors++; $display("FAIL rst_valid_b got %b required 0", down_valid_b); end
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL rst_up_ready got %b required 0", up_ready); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL post_rst_up_ready got %b required 1", up_ready); end
    checks++; if (down_data_a !== 6'h00) begin errors++; $display("FAIL post_rst_data_a got %h required 00", down_data_a); end
    checks++; if (down_data_b !== 6'h00) begin errors++; $display("FAIL post_rst_data_b got %h required 00", down_data_b); end
  endtask

  task automatic test_single();
    bit ok;
    int w;
    down_ready_a = 1'b1;
    down_ready_b = 1'b1;
    push_word(6'h15, 4, ok, w);
    checks++; if (!ok) begin errors++; $display("FAIL single_accept got timeout required accept"); end
    checks++; if (down_valid_a !== 1'b1 || down_data_a !== 6'h15) begin errors++; $display("FAIL single_out_a got %b/%h required 1/15", down_valid_a, down_data_a); end
    checks++; if (down_valid_b !== 1'b1 || down_data_b !== 6'h15) begin errors++; $display("FAIL single_out_b got %b/%h required 1/15", down_valid_b, down_data_b); end
    step();
    checks++; if (down_valid_a !== 1'b0 || down_valid_b !== 1'b0) begin errors++; $display("FAIL single_drained got %b%b required 00", down_valid_a, down_valid_b); end
  endtask

  task automatic test_stall_a();
    bit ok;
    int w;
    int pa0, pb0;
    pa0 = pop_a_n;
    pb0 = pop_b_n;
    down_ready_a = 1'b0;
    down_ready_b = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      push_word(6'(i), 4, ok, w);
      checks++; if (!ok || w != 0) begin errors++; $display("FAIL stall_push%0d got ok=%b waits=%0d required ok=1 waits=0", i, ok, w); end
    end
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL stall_full_ready got %b required 0", up_ready); end
    up_data = 6'h05;
    up_valid = 1'b1;
    repeat (3) step();
    checks++; if (up_ready !== 1'b0 || down_data_a !== 6'h01) begin errors++; $display("FAIL stall_hold got %b/%h required 0/01", up_ready, down_data_a); end
    down_ready_a = 1'b1;
    step();
    down_ready_a = 1'b0;
    checks++; if (up_ready !== 1'b1) begin errors++; $display("FAIL stall_reopen got %b required 1", up_ready); end
    step();
    up_valid = 1'b0;
    checks++; if (up_ready !== 1'b0) begin errors++; $display("FAIL stall_refull got %b required 0", up_ready); end
    down_ready_a = 1'b1;
    repeat (5) step();
    checks++; if (down_valid_a !== 1'b0 || exp_a.size() != 0 || exp_b.size() != 0) begin errors++; $display("FAIL stall_drain got valid_a=%b qa=%0d qb=%0d required 0/0/0", down_valid_a, exp_a.size(), exp_b.size()); end
    checks++; if (pop_a_n - pa0 != 5 || pop_b_n - pb0 != 5) begin errors++; $display("FAIL stall_counts got a=%0d b=%0d required 5/5", pop_a_n - pa0, pop_b_n - pb0); end
  endtask

  task automatic test_wrap();
    bit ok;
    int w;
    int wsum;
    int pa0;
    pa0 = pop_a_n;
    down_ready_a = 1'b0;
    down_ready_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_word(6'h10 + 6'(i), 4, ok, w);
      checks++; if (!ok) begin errors++; $display("FAIL wrap_fill%0d got timeout required accept", i); end
    end
    checks++; if (up_ready !== 1'b0 || down_data_a !== 6'h10 || down_data_b !== 6'h10) begin errors++; $display("FAIL wrap_full got %b/%h/%h required 0/10/10", up_ready, down_data_a, down_data_b); end
    down_ready_a = 1'b1;
    down_ready_b = 1'b1;
    wsum = 0;
    for (int i = 4; i < 12; i++) begin
      push_word(6'h10 + 6'(i), 4, ok, w);
      wsum += w;
      checks++; if (!ok) begin errors++; $display("FAIL wrap_push%0d got timeout required accept", i); end
    end
    checks++; if (wsum != 1) begin errors++; $display("FAIL wrap_stalls got %0d required 1", wsum); end
    repeat (6) step();
    checks++; if (pop_a_n - pa0 != 12 || exp_a.size() != 0 || exp_b.size() != 0) begin errors++; $display("FAIL wrap_total got %0d qa=%0d qb=%0d required 12/0/0", pop_a_n - pa0, exp_a.size(), exp_b.size()); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int w;
    int pa0, pb0;
    down_ready_a = 1'b0;
    down_ready_b = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push_word(6'h31 + 6'(i), 4, ok, w);
      checks++; if (!ok) begin errors++; $display("FAIL mid_push%0d got timeout required accept", i); end
    end
    down_ready_b = 1'b1;
    repeat (2) step();
    down_ready_b = 1'b0;
    checks++; if (down_data_a !== 6'h31 || down_data_b !== 6'h33) begin errors++; $display("FAIL mid_heads got %h/%h required 31/33", down_data_a, down_data_b); end
    #2;
    rst = 1'b0;
    #1;
    checks++; if (down_valid_a !== 1'b0 || down_valid_b !== 1'b0 || up_ready !== 1'b0) begin errors++; $display("FAIL mid_async got %b%b%b required 000", down_valid_a, down_valid_b, up_ready); end
    exp_a.delete();
    exp_b.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    step();
    checks++; if (down_valid_a !== 1'b0 || down_data_a !== 6'h00 || down_data_b !== 6'h00) begin errors++; $display("FAIL mid_cleared got %b/%h/%h required 0/00/00", down_valid_a, down_data_a, down_data_b); end
    pa0 = pop_a_n;
    pb0 = pop_b_n;
    down_ready_a = 1'b1;
    down_ready_b = 1'b1;
    push_word(6'h2A, 4, ok, w);
    checks++; if (!ok || down_data_a !== 6'h2A || down_data_b !== 6'h2A) begin errors++; $display("FAIL mid_first got %b/%h/%h required 1/2a/2a", ok, down_data_a, down_data_b); end
    repeat (2) step();
    checks++; if (pop_a_n - pa0 != 1 || pop_b_n - pb0 != 1 || exp_a.size() != 0) begin errors++; $display("FAIL mid_single got a=%0d b=%0d required 1/1", pop_a_n - pa0, pop_b_n - pb0); end
  endtask

`ifdef STREAM_FORK_CNT_EN
  task automatic test_counter();
    int p0;
    do_reset();
    checks++; if (cnt_a !== 16'd0 || cnt_b !== 16'd0) begin errors++; $display("FAIL cnt_reset got %h/%h required 0000/0000", cnt_a, cnt_b); end
    p0 = push_n;
    down_ready_a = 1'b1;
    down_ready_b = 1'b1;
    up_valid = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      up_data = 6'(i);
      step();
    end
    up_valid = 1'b0;
    repeat (3) step();
    checks++; if (push_n - p0 != 65537) begin errors++; $display("FAIL cnt_accepts got %0d required 65537", push_n - p0); end
    checks++; if (cnt_a !== 16'd1 || cnt_b !== 16'd1) begin errors++; $display("FAIL cnt_wrap got %h/%h required 0001/0001", cnt_a, cnt_b); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_stall_a();
    test_wrap();
    test_reset_mid();
`ifdef STREAM_FORK_CNT_EN
    test_counter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
